// File: rtl/m_store_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m_store_buf_pkg
// Brief    : Shared pipeline definitions: data-memory width codes and the
//            store-buffer entry record.
// Revision : 1.0 - initial release
// ============================================================================
package m_store_buf_pkg;

    localparam logic [1:0] c_DM_WORD = 2'b00;
    localparam logic [1:0] c_DM_BYTE = 2'b01;
    localparam logic [1:0] c_DM_HALF = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  op;
        logic [31:0] pc;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/m_store_buf_sb_match.sv
`default_nettype none
// ============================================================================
// Module   : sb_match
// Brief    : Word-address compare of a load against every live store-buffer
//            entry; reports a hit and the index of the youngest matching entry.
// Revision : 1.0 - initial release
// ============================================================================
module sb_match #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [PW-1:0]            rd_ptr,
    input  logic [PW:0]              count,
    input  logic [DEPTH-1:0][29:0]   entry_word,
    input  logic [29:0]              query_word,
    input  logic                     query_en,
    output logic                     hit,
    output logic [PW-1:0]            young_idx
);

    logic [PW-1:0] w_idx;

    // Walk entries oldest to youngest so the last hit is the youngest one.
    always_comb begin
        hit       = 1'b0;
        young_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = rd_ptr + PW'(k);
            if (query_en && ((PW+1)'(k) < count) && (entry_word[w_idx] == query_word)) begin
                hit       = 1'b1;
                young_idx = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_store_buf.sv
`default_nettype none
// ============================================================================
// Module   : m_store_buf
// Brief    : M-stage store buffer. Stores are queued and drained to data memory
//            one per cycle; loads get the port when the buffer can wait.
//            Optional store-to-load forwarding when STORE_BUF_FWD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module m_store_buf
    import m_store_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_req,
    input  logic        ld_req,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    input  logic [1:0]  DM_op,
    input  logic [31:0] PC,
    output logic        stall,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [1:0]  dm_op,
    output logic [31:0] dm_pc,
    output logic        fwd_valid,
    output logic [31:0] fwd_data,
    output logic        sb_empty
);

    localparam int              c_PW         = $clog2(DEPTH);
    localparam logic [c_PW:0]   c_COUNT_FULL = (c_PW+1)'(DEPTH);

    sb_entry_t              r_mem [DEPTH];
    logic [c_PW-1:0]        r_rd_ptr;
    logic [c_PW-1:0]        r_wr_ptr;
    logic [c_PW:0]          r_count;

    logic [DEPTH-1:0][29:0] w_entry_word;
    sb_entry_t              w_head;
    logic                   w_ld;
    logic                   w_hit;
    logic                   w_full;
    logic                   w_drain;
    logic                   w_fwd_valid;
    logic [31:0]            w_fwd_data;
    logic [c_PW-1:0]        w_young;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign w_entry_word[i] = r_mem[i].addr[31:2];
    end

    // A store in the same cycle wins: the load is not serviced, so it can
    // neither conflict, forward nor stall.
    assign w_ld   = ld_req & ~st_req;
    assign w_full = (r_count == c_COUNT_FULL);
    assign w_head = r_mem[r_rd_ptr];

    sb_match #(
        .DEPTH      (DEPTH),
        .PW         (c_PW)
    ) u_sb_match (
        .rd_ptr     (r_rd_ptr),
        .count      (r_count),
        .entry_word (w_entry_word),
        .query_word (addr[31:2]),
        .query_en   (w_ld),
        .hit        (w_hit),
        .young_idx  (w_young)
    );

`ifdef STORE_BUF_FWD_EN
    assign w_fwd_valid = w_hit && (DM_op == c_DM_WORD) && (r_mem[w_young].op == c_DM_WORD);
    assign w_fwd_data  = w_fwd_valid ? r_mem[w_young].data : 32'd0;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^w_young;
    assign w_fwd_valid  = 1'b0;
    assign w_fwd_data   = 32'd0;
`endif

    assign w_drain = (r_count != '0) && (!ld_req || w_full || w_hit || w_fwd_valid);

    assign stall     = w_ld & w_drain & ~w_fwd_valid;
    assign dm_we     = w_drain;
    assign dm_addr   = w_drain ? w_head.addr : addr;
    assign dm_wdata  = w_drain ? w_head.data : 32'd0;
    assign dm_op     = w_drain ? w_head.op   : DM_op;
    assign dm_pc     = w_drain ? w_head.pc   : PC;
    assign fwd_valid = w_fwd_valid;
    assign fwd_data  = w_fwd_data;
    assign sb_empty  = (r_count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (st_req) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_drain) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // When full, a store always coincides with a drain, so count holds.
            case ({st_req, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload carries no reset; liveness comes only from the pointers and count.
    always_ff @(posedge clk) begin
        if (st_req) begin
            r_mem[r_wr_ptr] <= '{addr: addr, data: writeData, op: DM_op, pc: PC};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_store_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_store_buf
// Brief    : Self-checking bench for m_store_buf against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_store_buf;
    import m_store_buf_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st_req = 1'b0;
    logic        ld_req = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writeData = '0;
    logic [1:0]  DM_op = '0;
    logic [31:0] PC = '0;
    logic        stall;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_op;
    logic [31:0] dm_pc;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        sb_empty;

    m_store_buf #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_req    (st_req),
        .ld_req    (ld_req),
        .addr      (addr),
        .writeData (writeData),
        .DM_op     (DM_op),
        .PC        (PC),
        .stall     (stall),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_op     (dm_op),
        .dm_pc     (dm_pc),
        .fwd_valid (fwd_valid),
        .fwd_data  (fwd_data),
        .sb_empty  (sb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  op;
        logic [31:0] pc;
    } ent_t;

    ent_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input logic st, input logic ld, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] op, input logic [31:0] pc);
        bit   eff_ld;
        bit   hit;
        bit   fwd;
        bit   drain;
        int   young;
        ent_t hd;
        ent_t e;
        st_req = st; ld_req = ld; addr = a; writeData = d; DM_op = op; PC = pc;
        eff_ld = ld && !st;
        hit    = 1'b0;
        young  = 0;
        if (eff_ld) begin
            foreach (sbq[i]) begin
                if (sbq[i].addr[31:2] == a[31:2]) begin
                    hit   = 1'b1;
                    young = i;
                end
            end
        end
        fwd = 1'b0;
`ifdef STORE_BUF_FWD_EN
        fwd = hit && (op == c_DM_WORD) && (sbq[young].op == c_DM_WORD);
`endif
        drain = (sbq.size() > 0) && (!ld || sbq.size() == DEPTH || hit || fwd);
        hd = '{addr: '0, data: '0, op: '0, pc: '0};
        if (sbq.size() > 0) hd = sbq[0];
        @(negedge clk);
        chk("stall",     32'(stall),     32'(eff_ld && drain && !fwd));
        chk("dm_we",     32'(dm_we),     32'(drain));
        chk("dm_addr",   dm_addr,        drain ? hd.addr : a);
        chk("dm_wdata",  dm_wdata,       drain ? hd.data : 32'd0);
        chk("dm_op",     32'(dm_op),     32'(drain ? hd.op : op));
        chk("dm_pc",     dm_pc,          drain ? hd.pc : pc);
        chk("fwd_valid", 32'(fwd_valid), 32'(fwd));
        chk("fwd_data",  fwd_data,       fwd ? sbq[young].data : 32'd0);
        chk("sb_empty",  32'(sb_empty),  32'(sbq.size() == 0));
        @(posedge clk);
        #1;
        if (drain) void'(sbq.pop_front());
        if (st) begin
            e = '{addr: a, data: d, op: op, pc: pc};
            sbq.push_back(e);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, c_DM_WORD, 32'h0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dm_we"},     32'(dm_we),     32'd0);
        chk({tag, "_stall"},     32'(stall),     32'd0);
        chk({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
        chk({tag, "_fwd_data"},  fwd_data,       32'd0);
        chk({tag, "_sb_empty"},  32'(sb_empty),  32'd1);
    endtask

    initial begin
        // Asynchronous reset seen before any clock edge.
        #1 reset = 1'b1;
        #1 chk_reset_state("por");
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word store drains on the following cycle.
        cycle(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, c_DM_WORD, 32'h1000);
        idle();
        chk("st_then_empty", 32'(sb_empty), 32'd1);

        // Fill with loads present (no drain), fifth store forces head out.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, 32'h200 + 32'(i * 4), $urandom, c_DM_WORD, 32'h2000 + 32'(i * 4));
        cycle(1'b0, 1'b1, 32'h100, 32'h0, c_DM_WORD, 32'h2100);
        repeat (5) idle();

        // Byte store then conflicting word load: stalls until drained.
        cycle(1'b1, 1'b0, 32'h21, 32'h000000AB, c_DM_BYTE, 32'h3000);
        cycle(1'b0, 1'b1, 32'h20, 32'h0, c_DM_WORD, 32'h3004);
        cycle(1'b0, 1'b1, 32'h20, 32'h0, c_DM_WORD, 32'h3004);
        cycle(1'b0, 1'b1, 32'h22, 32'h0, c_DM_HALF, 32'h3008);

        // Two stores to one word, then a word load: youngest entry wins.
        cycle(1'b1, 1'b1, 32'h40, 32'h11111111, c_DM_WORD, 32'h4000);
        cycle(1'b1, 1'b1, 32'h40, 32'h22222222, c_DM_WORD, 32'h4004);
        cycle(1'b0, 1'b1, 32'h40, 32'h0, c_DM_WORD, 32'h4008);
        repeat (3) idle();

        // Three pending stores, reset pulsed between clock edges.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 32'h500 + 32'(i * 4), $urandom, c_DM_WORD, 32'h5000 + 32'(i * 4));
        st_req = 1'b0;
        ld_req = 1'b0;
        #1 chk("pre_reset_we", 32'(dm_we), 32'd1);
        #1 reset = 1'b1;
        #1 chk_reset_state("mid");
        sbq.delete();
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) idle();

        // Pointer wrap: ten store/idle pairs drain in order.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 32'h600 + 32'(i * 4), $urandom, c_DM_WORD, 32'h6000 + 32'(i * 4));
            idle();
        end

        // Randomised traffic over a small address window to provoke conflicts.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
                  $urandom, 2'($urandom_range(0, 2)), $urandom);
        end
        repeat (DEPTH + 1) idle();
        chk("final_empty", 32'(sb_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_store_buf.md
M_STORE_BUF -- requirements
Module: m_store_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port st_req  in  1  M-stage instruction is a store (sw/sh/sb).
REQ-005 SHALL have port ld_req  in  1  M-stage instruction is a load (lw/lh/lb).
REQ-006 SHALL have port addr  in  32  byte address of the M-stage access.
REQ-007 SHALL have port writeData  in  32  store data, unshifted, low bits significant.
REQ-008 SHALL have port DM_op  in  2  width code: 00 word, 01 byte, 10 half.
REQ-009 SHALL have port PC  in  32  PC of the M-stage instruction.
REQ-010 SHALL have port stall  out  1  freeze F/D/E/M for this cycle.
REQ-011 SHALL have ports dm_we (1), dm_addr (32), dm_wdata (32), dm_op (2), dm_pc (32), all out, driving the data-memory write enable, address, data, width code and trace PC.
REQ-012 SHALL have ports fwd_valid  out  1 and fwd_data  out  32  load result supplied from the buffer.
REQ-013 SHALL have port sb_empty  out  1  no pending stores.

Function
REQ-014 SHALL hold pending stores as {addr, data, op, pc} in a FIFO with rd_ptr, wr_ptr (wrap modulo DEPTH) and count (0..DEPTH).
REQ-015 SHALL flag conflict when ld_req=1 and any valid entry has addr[31:2] equal to addr[31:2].
REQ-016 SHALL assert drain when count>0 and (ld_req=0, or count==DEPTH, or conflict, or fwd_valid); one entry drains per cycle, oldest first.
REQ-017 SHALL, when draining, drive dm_we=1 with dm_addr/dm_wdata/dm_op/dm_pc from the head entry and advance rd_ptr on the clock edge.
REQ-018 SHALL, when not draining, drive dm_we=0, dm_addr=addr, dm_op=DM_op, dm_pc=PC, dm_wdata=0, giving the load the memory port.
REQ-019 SHALL assert stall = ld_req & drain & ~fwd_valid; loads retry until conflict clears and the port is free.
REQ-020 SHALL never stall a store: st_req enqueues at wr_ptr on the edge; at count==DEPTH the same-cycle drain frees the slot, so enqueue and dequeue occur together and count is unchanged.
REQ-021 SHALL NOT bypass a store straight to memory: a store accepted while empty drains no earlier than the next cycle.
REQ-022 SHALL treat st_req=ld_req=1 as a store; ld_req is ignored that cycle.
REQ-023 SHALL drive sb_empty = (count==0) combinationally.

Reset
REQ-024 SHALL, on reset assertion, immediately clear count, rd_ptr and wr_ptr, so that dm_we=0, stall=0, fwd_valid=0, fwd_data=0 and sb_empty=1 hold without waiting for a clock; pending stores are discarded, including those in flight mid-drain.
REQ-025 SHALL leave entry payload registers unreset; validity is derived solely from the pointers and count.

Configuration
REQ-026 SHALL compile store-to-load forwarding only when STORE_BUF_FWD_EN is defined.
REQ-027 SHALL, with STORE_BUF_FWD_EN defined, drive fwd_valid=1 and fwd_data to the youngest conflicting entry's data when ld_req=1, DM_op=word, that entry's op is word and its addr[31:2] matches; otherwise fwd_valid=0.
REQ-028 SHALL, without STORE_BUF_FWD_EN, tie fwd_valid=0 and fwd_data=0, so every conflicting load stalls until drained.

Structure
REQ-029 SHALL take the width codes (word 00, byte 01, half 10) from the shared pipeline package, and SHALL place the entry record typedef there.
REQ-030 SHALL use one sub-module, sb_match, for combinational per-entry word-address compare and youngest-match priority select.

Verification
REQ-031 SHALL verify: reset, then st_req sw addr 0x10 data 0xDEADBEEF, no load -> next cycle dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF; sb_empty=1 after.
REQ-032 SHALL verify: 4 back-to-back stores with ld_req=1 to non-matching 0x100 -> no drain, stall=0; fifth store -> head drains, count stays 4.
REQ-033 SHALL verify: sb to 0x21 pending, lw 0x20 -> stall=1 until the entry drains, then stall=0 and dm_addr=0x20.
REQ-034 SHALL verify, with STORE_BUF_FWD_EN: sw 0x40 0x11111111, then sw 0x40 0x22222222, then lw 0x40 -> fwd_valid=1, fwd_data=0x22222222, stall=0.
REQ-035 SHALL verify: three stores pending, reset pulsed between clock edges -> dm_we=0 and sb_empty=1 immediately, with no later write to memory.
REQ-036 SHALL verify: pointer wrap -> 10 stores each followed by one idle cycle drain to memory in order with matching dm_pc.
